// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arch_defs_pkg
//  Brief    : SAP-1.5 shared types: opcodes, ALU ops, FSM states, control word
//  Revision : 1.0
// ============================================================================
package arch_defs_pkg;

  localparam int OPCODE_WIDTH    = 4;
  localparam int MICROSTEP_WIDTH = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP  = 4'b0000,
    OP_LDA  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_STA  = 4'b0111,
    OP_LDI  = 4'b1000,
    OP_JMP  = 4'b1001,
    OP_JC   = 4'b1010,
    OP_JZ   = 4'b1011,
    OP_OUTM = 4'b1101,
    OP_OUTA = 4'b1110,
    OP_HLT  = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_FETCH_0  = 3'd1,
    S_FETCH_1  = 3'd2,
    S_DECODE_0 = 3'd3,
    S_DECODE_1 = 3'd4,
    S_EXECUTE  = 3'd5,
    S_HALT     = 3'd6,
    S_WAIT     = 3'd7
  } fsm_state_t;

  typedef logic [MICROSTEP_WIDTH-1:0] microstep_t;

  localparam microstep_t MS0 = 4'd0;
  localparam microstep_t MS1 = 4'd1;
  localparam microstep_t MS2 = 4'd2;

  typedef struct packed {
    logic    halt;
    logic    oe_pc;
    logic    load_mar;
    logic    oe_ram;
    logic    load_ir;
    logic    pc_enable;
    logic    oe_ir;
    logic    load_a;
    logic    load_b;
    logic    oe_alu;
    logic    load_flags;
    alu_op_t alu_op;
    logic    load_ram;
    logic    oe_a;
    logic    load_pc;
    logic    check_carry;
    logic    check_zero;
    logic    load_o;
    logic    last_step;
  } control_word_t;

  localparam control_word_t CW_NOP = '0;

  function automatic alu_op_t alu_op_for(input opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : microcode_sequencer_if
//  Brief    : Opcode/flag inputs and control/debug outputs of the sequencer
//  Revision : 1.0
// ============================================================================
interface microcode_sequencer_if
  import arch_defs_pkg::*;
();

  opcode_t       opcode_in;
  logic          flag_zero;
  logic          flag_carry;
  control_word_t control_word;
  fsm_state_t    state;
  microstep_t    microstep;

  modport master (
    input  opcode_in, flag_zero, flag_carry,
    output control_word, state, microstep
  );

  modport slave (
    output opcode_in, flag_zero, flag_carry,
    input  control_word, state, microstep
  );

endinterface
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// ============================================================================
//  Module   : microcode_rom
//  Brief    : Combinational execute-phase control word per opcode/microstep
//  Revision : 1.0
// ============================================================================
module microcode_rom
  import arch_defs_pkg::*;
(
  input  opcode_t       opcode_i,
  input  microstep_t    microstep_i,
  input  logic          flag_zero_i,
  input  logic          flag_carry_i,
  output control_word_t control_word_o
);

  always_comb begin
    control_word_o = CW_NOP;
    // Unreachable steps emit a bare last_step so the sequencer resyncs to fetch.
    if (microstep_i > MS2) begin
      control_word_o.last_step = 1'b1;
    end else begin
      case (opcode_i)
        OP_LDA, OP_LDB, OP_STA, OP_OUTM: begin
          case (microstep_i)
            MS0: begin
              control_word_o.oe_ir    = 1'b1;
              control_word_o.load_mar = 1'b1;
            end
            MS1: begin
              control_word_o.last_step = 1'b1;
              case (opcode_i)
                OP_LDA: begin
                  control_word_o.oe_ram = 1'b1;
                  control_word_o.load_a = 1'b1;
                end
                OP_LDB: begin
                  control_word_o.oe_ram = 1'b1;
                  control_word_o.load_b = 1'b1;
                end
                OP_STA: begin
                  control_word_o.oe_a     = 1'b1;
                  control_word_o.load_ram = 1'b1;
                end
                default: begin
                  control_word_o.oe_ram = 1'b1;
                  control_word_o.load_o = 1'b1;
                end
              endcase
            end
            default: control_word_o.last_step = 1'b1;
          endcase
        end

        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          case (microstep_i)
            MS0: begin
              control_word_o.oe_ir    = 1'b1;
              control_word_o.load_mar = 1'b1;
            end
            MS1: begin
              control_word_o.oe_ram = 1'b1;
              control_word_o.load_b = 1'b1;
            end
            default: begin
              control_word_o.alu_op     = alu_op_for(opcode_i);
              control_word_o.oe_alu     = 1'b1;
              control_word_o.load_a     = 1'b1;
              control_word_o.load_flags = 1'b1;
              control_word_o.last_step  = 1'b1;
            end
          endcase
        end

        OP_LDI: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.oe_ir  = 1'b1;
            control_word_o.load_a = 1'b1;
          end
        end

        OP_JMP: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.oe_ir   = 1'b1;
            control_word_o.load_pc = 1'b1;
          end
        end

        OP_JC: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.oe_ir       = 1'b1;
            control_word_o.check_carry = 1'b1;
            control_word_o.load_pc     = flag_carry_i;
          end
        end

        OP_JZ: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.oe_ir      = 1'b1;
            control_word_o.check_zero = 1'b1;
            control_word_o.load_pc    = flag_zero_i;
          end
        end

        OP_OUTA: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.oe_a   = 1'b1;
            control_word_o.load_o = 1'b1;
          end
        end

        OP_HLT: begin
          control_word_o.last_step = 1'b1;
          if (microstep_i == MS0) begin
            control_word_o.halt = 1'b1;
          end
        end

        // NOP and the undefined 4'b1100 encoding
        default: control_word_o.last_step = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : microcode_sequencer
//  Brief    : SAP-1.5 fetch/decode/execute FSM driving the datapath control word
//  Revision : 1.0
// ============================================================================
module microcode_sequencer
  import arch_defs_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  microcode_sequencer_if.master bus
);

  fsm_state_t    state_q, state_d;
  microstep_t    microstep_q, microstep_d;
  opcode_t       opcode_q, opcode_d;
  control_word_t rom_word;
  control_word_t cw;

  microcode_rom u_rom (
    .opcode_i       (opcode_q),
    .microstep_i    (microstep_q),
    .flag_zero_i    (bus.flag_zero),
    .flag_carry_i   (bus.flag_carry),
    .control_word_o (rom_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      microstep_q <= MS0;
      opcode_q    <= OP_NOP;
    end else begin
      state_q     <= state_d;
      microstep_q <= microstep_d;
      opcode_q    <= opcode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    microstep_d = microstep_q;
    opcode_d    = opcode_q;
    cw          = CW_NOP;

    case (state_q)
      S_RESET: begin
        microstep_d = MS0;
        state_d     = S_FETCH_0;
      end

      S_FETCH_0: begin
        cw.oe_pc    = 1'b1;
        cw.load_mar = 1'b1;
        state_d     = S_FETCH_1;
      end

      S_FETCH_1: begin
        cw.oe_ram    = 1'b1;
        cw.load_ir   = 1'b1;
        cw.pc_enable = 1'b1;
        state_d      = S_DECODE_0;
      end

      // IR is valid here; capture it so later opcode_in changes are ignored.
      S_DECODE_0: begin
        opcode_d    = bus.opcode_in;
        microstep_d = MS0;
        state_d     = S_EXECUTE;
      end

      S_EXECUTE: begin
        cw = rom_word;
        if (rom_word.last_step) begin
          microstep_d = MS0;
          state_d     = rom_word.halt ? S_HALT : S_FETCH_0;
        end else begin
          microstep_d = microstep_q + 4'd1;
        end
      end

      S_HALT: begin
        cw.halt = 1'b1;
      end

      // S_DECODE_1 / S_WAIT are never entered intentionally.
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign bus.control_word = cw;
  assign bus.state        = state_q;
  assign bus.microstep    = microstep_q;

endmodule
`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microcode_sequencer
//  Brief    : Self-checking bench for the SAP-1.5 microcode sequencer
//  Revision : 1.0
// ============================================================================
module tb_microcode_sequencer;
  import arch_defs_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  microcode_sequencer_if bus ();

  microcode_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction length in cycles, taken straight from the timing table.
  function automatic int exp_len(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:   return 6;
      OP_LDA, OP_LDB, OP_STA, OP_OUTM: return 5;
      default:                         return 4;
    endcase
  endfunction

  function automatic bit uses_mem_operand(input opcode_t op);
    return op inside {OP_LDA, OP_LDB, OP_STA, OP_OUTM, OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction

  // Reference: address step first for memory-operand ops, one read step for
  // ALU ops, then the instruction's final action tagged with last_step.
  function automatic control_word_t exp_exec(input opcode_t op, input int k, input bit z, input bit c);
    control_word_t w;
    int n;
    w = CW_NOP;
    n = exp_len(op) - 3;
    if (uses_mem_operand(op) && k == 0) begin
      w.oe_ir = 1'b1; w.load_mar = 1'b1;
    end else if (k < n - 1) begin
      w.oe_ram = 1'b1; w.load_b = 1'b1;
    end else begin
      w.last_step = 1'b1;
      case (op)
        OP_LDA:  begin w.oe_ram = 1'b1; w.load_a = 1'b1; end
        OP_LDB:  begin w.oe_ram = 1'b1; w.load_b = 1'b1; end
        OP_STA:  begin w.oe_a = 1'b1; w.load_ram = 1'b1; end
        OP_OUTM: begin w.oe_ram = 1'b1; w.load_o = 1'b1; end
        OP_ADD:  begin w.alu_op = ALU_ADD; w.oe_alu = 1'b1; w.load_a = 1'b1; w.load_flags = 1'b1; end
        OP_SUB:  begin w.alu_op = ALU_SUB; w.oe_alu = 1'b1; w.load_a = 1'b1; w.load_flags = 1'b1; end
        OP_AND:  begin w.alu_op = ALU_AND; w.oe_alu = 1'b1; w.load_a = 1'b1; w.load_flags = 1'b1; end
        OP_OR:   begin w.alu_op = ALU_OR;  w.oe_alu = 1'b1; w.load_a = 1'b1; w.load_flags = 1'b1; end
        OP_LDI:  begin w.oe_ir = 1'b1; w.load_a = 1'b1; end
        OP_JMP:  begin w.oe_ir = 1'b1; w.load_pc = 1'b1; end
        OP_JC:   begin w.oe_ir = 1'b1; w.check_carry = 1'b1; w.load_pc = c; end
        OP_JZ:   begin w.oe_ir = 1'b1; w.check_zero = 1'b1; w.load_pc = z; end
        OP_OUTA: begin w.oe_a = 1'b1; w.load_o = 1'b1; end
        OP_HLT:  w.halt = 1'b1;
        default: ;
      endcase
    end
    return w;
  endfunction

  function automatic control_word_t exp_fetch0();
    control_word_t w;
    w = CW_NOP; w.oe_pc = 1'b1; w.load_mar = 1'b1;
    return w;
  endfunction

  function automatic control_word_t exp_fetch1();
    control_word_t w;
    w = CW_NOP; w.oe_ram = 1'b1; w.load_ir = 1'b1; w.pc_enable = 1'b1;
    return w;
  endfunction

  function automatic control_word_t exp_halt();
    control_word_t w;
    w = CW_NOP; w.halt = 1'b1;
    return w;
  endfunction

  task automatic chk_oe_onehot(input string tag);
    control_word_t w;
    w = bus.control_word;
    chk(tag, 32'($countones({w.oe_pc, w.oe_ram, w.oe_ir, w.oe_alu, w.oe_a}) <= 1), 32'd1);
  endtask

  // Runs one instruction starting at the FETCH_0 cycle. With rand_inputs the
  // opcode bus and flags are scrambled every execute cycle; otherwise opcode_in
  // is driven to ~op during execute. abort_at >= 0 asserts reset mid-step.
  task automatic run_instr(input opcode_t op, input bit z, input bit c,
                           input bit rand_inputs, input int abort_at);
    int n;
    n = exp_len(op) - 3;
    bus.opcode_in = op;
    #1;
    chk("fetch0_state", bus.state, S_FETCH_0);
    chk("fetch0_cw", bus.control_word, exp_fetch0());
    tick();
    #1;
    chk("fetch1_state", bus.state, S_FETCH_1);
    chk("fetch1_cw", bus.control_word, exp_fetch1());
    tick();
    #1;
    chk("decode_state", bus.state, S_DECODE_0);
    chk("decode_cw", bus.control_word, CW_NOP);
    tick();
    for (int k = 0; k < n; k++) begin
      if (rand_inputs) begin
        bus.opcode_in = opcode_t'(4'($urandom_range(0, 15)));
        z = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
      end else begin
        bus.opcode_in = opcode_t'(~op);
      end
      bus.flag_zero  = z;
      bus.flag_carry = c;
      #1;
      chk("exec_state", bus.state, S_EXECUTE);
      chk("exec_microstep", bus.microstep, 32'(k));
      chk("exec_cw", bus.control_word, exp_exec(op, k, z, c));
      chk_oe_onehot("exec_oe_onehot");
      if (k == abort_at) begin
        #3;
        reset = 1'b1;
        #1;
        chk("abort_cw", bus.control_word, CW_NOP);
        chk("abort_state", bus.state, S_RESET);
        chk("abort_microstep", bus.microstep, 32'(MS0));
        tick();
        reset = 1'b0;
        #1;
        chk("abort_release_state", bus.state, S_RESET);
        chk("abort_release_cw", bus.control_word, CW_NOP);
        tick();
        return;
      end
      tick();
    end
  endtask

  initial begin
    opcode_t op;
    reset          = 1'b1;
    bus.opcode_in  = OP_NOP;
    bus.flag_zero  = 1'b0;
    bus.flag_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", bus.state, S_RESET);
    chk("reset_cw", bus.control_word, CW_NOP);
    chk("reset_microstep", bus.microstep, 32'(MS0));
    reset = 1'b0;
    #1;
    chk("release_state", bus.state, S_RESET);
    chk("release_cw", bus.control_word, CW_NOP);
    tick();

    run_instr(OP_NOP,  1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_ADD,  1'b1, 1'b1, 1'b0, -1);
    run_instr(OP_SUB,  1'b0, 1'b1, 1'b0, -1);
    run_instr(OP_AND,  1'b1, 1'b0, 1'b0, -1);
    run_instr(OP_OR,   1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_LDA,  1'b0, 1'b0, 1'b0, -1);   // opcode_in flips to OUTA during execute
    run_instr(OP_LDB,  1'b1, 1'b1, 1'b0, -1);
    run_instr(OP_STA,  1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_LDI,  1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_JMP,  1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_JC,   1'b1, 1'b0, 1'b0, -1);
    run_instr(OP_JC,   1'b0, 1'b1, 1'b0, -1);
    run_instr(OP_JZ,   1'b0, 1'b1, 1'b0, -1);
    run_instr(OP_JZ,   1'b1, 1'b0, 1'b0, -1);
    run_instr(OP_OUTM, 1'b0, 1'b0, 1'b0, -1);
    run_instr(OP_OUTA, 1'b0, 1'b0, 1'b0, -1);
    run_instr(opcode_t'(4'b1100), 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      do op = opcode_t'(4'($urandom_range(0, 15))); while (op == OP_HLT);
      run_instr(op, 1'b0, 1'b0, 1'b1, -1);
    end

    run_instr(OP_HLT, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      bus.opcode_in  = opcode_t'(4'($urandom_range(0, 15)));
      bus.flag_zero  = 1'($urandom_range(0, 1));
      bus.flag_carry = 1'($urandom_range(0, 1));
      #1;
      chk("halt_state", bus.state, S_HALT);
      chk("halt_cw", bus.control_word, exp_halt());
      tick();
    end
    reset = 1'b1;
    #1;
    chk("halt_reset_state", bus.state, S_RESET);
    chk("halt_reset_cw", bus.control_word, CW_NOP);
    tick();
    reset = 1'b0;
    #1;
    chk("halt_release_state", bus.state, S_RESET);
    tick();

    run_instr(OP_SUB, 1'b0, 1'b0, 1'b1, 1);
    run_instr(OP_ADD, 1'b0, 1'b0, 1'b1, -1);
    run_instr(OP_NOP, 1'b0, 1'b0, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
